// File: rtl/ram_arb.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// One request per cycle, one owed response tracked by the FSM, held under back-pressure.
module ram_arb #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req_valid_i,
  output logic          m0_req_ready_o,
  input  logic [31:0]   m0_addr_i,
  input  logic [31:0]   m0_data_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  output logic [31:0]   m0_data_o,
  output logic          m0_rsp_valid_o,
  input  logic          m0_rsp_ready_i,
  input  logic          m1_req_valid_i,
  output logic          m1_req_ready_o,
  input  logic [31:0]   m1_addr_i,
  input  logic [31:0]   m1_data_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  output logic [31:0]   m1_data_o,
  output logic          m1_rsp_valid_o,
  input  logic          m1_rsp_ready_i,
  output logic [AW-1:0] s_addr_o,
  output logic [31:0]   s_data_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  input  logic [31:0]   s_data_i
);

  typedef enum logic [1:0] {IDLE, RSP0, RSP1} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        first_q, first_d;
  logic        rd_q, rd_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic        can_fire;
  logic        fire;
  logic        grant;
  logic        grant_we;
  logic [31:0] rsp_now;
  logic [31:0] rsp_out;

  // Address bits outside the word index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr_i[31:AW+2], m0_addr_i[1:0],
                              m1_addr_i[31:AW+2], m1_addr_i[1:0]};

  always_comb begin
    can_fire = rst_n && ((state_q == IDLE) ||
                         (state_q == RSP0 && m0_rsp_ready_i) ||
                         (state_q == RSP1 && m1_rsp_ready_i));

    if (m0_req_valid_i && m1_req_valid_i) grant = ~last_grant_q;
    else                                  grant = ~m0_req_valid_i;

    fire           = can_fire && (m0_req_valid_i || m1_req_valid_i);
    m0_req_ready_o = fire && !grant;
    m1_req_ready_o = fire && grant;

    if (grant) begin
      s_addr_o = m1_addr_i[AW+1:2];
      s_data_o = m1_data_i;
      s_sel_o  = m1_sel_i;
      grant_we = m1_we_i;
    end else begin
      s_addr_o = m0_addr_i[AW+1:2];
      s_data_o = m0_data_i;
      s_sel_o  = m0_sel_i;
      grant_we = m0_we_i;
    end
    s_we_o = fire && grant_we;

    // RAM data is only valid on the first response cycle; afterwards the register holds it.
    rsp_now   = rd_q ? s_data_i : 32'h0;
    rsp_out   = first_q ? rsp_now : rsp_data_q;
    m0_data_o = rsp_out;
    m1_data_o = rsp_out;

    m0_rsp_valid_o = rst_n && (state_q == RSP0);
    m1_rsp_valid_o = rst_n && (state_q == RSP1);

    state_d      = state_q;
    last_grant_d = last_grant_q;
    first_d      = fire;
    rd_d         = rd_q;
    rsp_data_d   = rsp_out;

    if (fire) begin
      state_d      = grant ? RSP1 : RSP0;
      last_grant_d = grant;
      rd_d         = !grant_we;
    end else if (can_fire && state_q != IDLE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      first_q      <= 1'b0;
      rd_q         <= 1'b0;
      rsp_data_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      first_q      <= first_d;
      rd_q         <= rd_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (owed response, round-robin winner, word memory).
module tb_ram_arb;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req_valid_i, m0_req_ready_o, m0_we_i, m0_rsp_valid_o, m0_rsp_ready_i;
  logic          m1_req_valid_i, m1_req_ready_o, m1_we_i, m1_rsp_valid_o, m1_rsp_ready_i;
  logic [31:0]   m0_addr_i, m0_data_i, m0_data_o, m1_addr_i, m1_data_i, m1_data_o;
  logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
  logic [AW-1:0] s_addr_o;
  logic [31:0]   s_data_o, s_data_i;
  logic          s_we_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_arb #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_data_o(m0_data_o), .m0_rsp_valid_o(m0_rsp_valid_o), .m0_rsp_ready_i(m0_rsp_ready_i),
    .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_data_o(m1_data_o), .m1_rsp_valid_o(m1_rsp_valid_o), .m1_rsp_ready_i(m1_rsp_ready_i),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_data_i(s_data_i)
  );

  // Synchronous-read RAM fixture.
  logic [31:0] mem [0:(1<<AW)-1];

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] sel);
    logic [31:0] mask;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  always @(posedge clk) begin
    if (s_we_o) mem[s_addr_o] <= byte_merge(mem[s_addr_o], s_data_o, s_sel_o);
    s_data_i <= mem[s_addr_o];
  end

  // Reference model state
  int          owed;       // -1: nothing owed, else requester owed a response
  int          last;       // requester granted most recently
  logic [31:0] owed_data;
  logic [31:0] ref_mem [0:(1<<AW)-1];

  // Per-cycle observations for the directed checks
  logic        o_r0, o_r1, o_v0, o_v1, o_we, fired;
  logic [31:0] o_d0, o_d1;
  int          fire_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int          g;
    logic        cf, f, we;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [AW-1:0] w;
    @(negedge clk);
    o_r0 = m0_req_ready_o; o_r1 = m1_req_ready_o;
    o_v0 = m0_rsp_valid_o; o_v1 = m1_rsp_valid_o;
    o_we = s_we_o; o_d0 = m0_data_o; o_d1 = m1_data_o;
    if (!rst_n) begin
      chk("rst_req_ready0", 32'(o_r0), 32'd0);
      chk("rst_req_ready1", 32'(o_r1), 32'd0);
      chk("rst_rsp_valid0", 32'(o_v0), 32'd0);
      chk("rst_rsp_valid1", 32'(o_v1), 32'd0);
      chk("rst_s_we", 32'(o_we), 32'd0);
      owed  = -1;
      last  = 1;
      fired = 1'b0;
      fire_g = -1;
    end else begin
      cf = (owed < 0) || (owed == 0 && m0_rsp_ready_i) || (owed == 1 && m1_rsp_ready_i);
      if (m0_req_valid_i && m1_req_valid_i) g = 1 - last;
      else                                  g = m0_req_valid_i ? 0 : 1;
      f = cf && (m0_req_valid_i || m1_req_valid_i);
      chk("req_ready0", 32'(o_r0), 32'(f && g == 0));
      chk("req_ready1", 32'(o_r1), 32'(f && g == 1));
      chk("rsp_valid0", 32'(o_v0), 32'(owed == 0));
      chk("rsp_valid1", 32'(o_v1), 32'(owed == 1));
      if (owed >= 0) begin
        chk("rsp_data0", o_d0, owed_data);
        chk("rsp_data1", o_d1, owed_data);
      end
      if (f) begin
        if (g == 0) begin a = m0_addr_i; d = m0_data_i; s = m0_sel_i; we = m0_we_i; end
        else        begin a = m1_addr_i; d = m1_data_i; s = m1_sel_i; we = m1_we_i; end
        w = a[AW+1:2];
        chk("s_addr", 32'(s_addr_o), 32'(w));
        chk("s_we", 32'(o_we), 32'(we));
        if (we) begin
          chk("s_data", s_data_o, d);
          chk("s_sel", 32'(s_sel_o), 32'(s));
          for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
          owed_data = 32'h0;
        end else begin
          owed_data = ref_mem[w];
        end
        owed = g;
        last = g;
      end else begin
        chk("s_we_nofire", 32'(o_we), 32'd0);
        if (cf && owed >= 0) owed = -1;
      end
      fired  = f;
      fire_g = f ? g : -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    m0_req_valid_i = 1'b0; m1_req_valid_i = 1'b0;
    m0_we_i = 1'b0; m1_we_i = 1'b0;
    m0_sel_i = 4'hF; m1_sel_i = 4'hF;
    m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    quiet();
    m0_addr_i = '0; m1_addr_i = '0; m0_data_i = '0; m1_data_i = '0;
    owed = -1; last = 1; owed_data = '0;
    @(posedge clk); #1;
    cycle();
    // A write presented during reset must not reach the RAM.
    m0_req_valid_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h10; m0_data_i = 32'hBAD0BAD0;
    cycle();
    rst_n = 1'b1;
    quiet();
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle_s_we", 32'(o_we), 32'd0);
    end

    // Preload words 0..15 through the arbiter, back to back.
    for (int i = 0; i < 16; i++) begin
      m0_req_valid_i = 1'b1; m0_we_i = 1'b1; m0_sel_i = 4'hF;
      m0_addr_i = 32'(i) << 2; m0_data_i = $urandom;
      cycle();
    end

    // Single read
    m0_addr_i = 32'h10; m0_data_i = 32'hDEADBEEF;
    cycle();
    m0_we_i = 1'b0;
    cycle();
    chk("rd_fire", 32'(o_r0), 32'd1);
    quiet();
    cycle();
    chk("rd_rsp_valid", 32'(o_v0), 32'd1);
    chk("rd_data", o_d0, 32'hDEADBEEF);

    // m1 write so that m0 wins the upcoming conflict
    m1_req_valid_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h40; m1_data_i = 32'h55AA00FF;
    cycle();

    // Conflict
    m0_req_valid_i = 1'b1; m0_we_i = 1'b0; m1_we_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("conflict_fire", 32'(fired), 32'd1);
      chk("conflict_grant", 32'(fire_g), 32'(i % 2));
    end

    // Back-pressure on m1
    m0_req_valid_i = 1'b0;
    cycle();
    chk("bp_grant", 32'(fire_g), 32'd1);
    m1_req_valid_i = 1'b0; m0_req_valid_i = 1'b1; m1_rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_rsp_valid1", 32'(o_v1), 32'd1);
      chk("bp_data1", o_d1, 32'h55AA00FF);
      chk("bp_ready0", 32'(o_r0), 32'd0);
    end
    m1_rsp_ready_i = 1'b1;
    cycle();
    chk("bp_release_ready0", 32'(o_r0), 32'd1);
    quiet();
    cycle();

    // Byte write then read back
    m0_req_valid_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h20; m0_data_i = 32'h11223344;
    cycle();
    m0_sel_i = 4'b0010; m0_data_i = 32'h0000AB00;
    cycle();
    m0_we_i = 1'b0; m0_sel_i = 4'hF;
    cycle();
    chk("wr_rsp_data", o_d0, 32'h0);
    quiet();
    cycle();
    chk("byte_rd_valid", 32'(o_v0), 32'd1);
    chk("byte_rd_data", o_d0, 32'h1122AB44);

    // Reset while a response is owed to m0
    m0_req_valid_i = 1'b1; m0_addr_i = 32'h20; m0_rsp_ready_i = 1'b0;
    cycle();
    m0_req_valid_i = 1'b0;
    rst_n = 1'b0;
    cycle();
    chk("rst_in_rsp_valid0", 32'(o_v0), 32'd0);
    rst_n = 1'b1; m0_rsp_ready_i = 1'b1;
    cycle();
    chk("post_rst_valid0", 32'(o_v0), 32'd0);
    m0_req_valid_i = 1'b1; m1_req_valid_i = 1'b1; m1_addr_i = 32'h40;
    cycle();
    chk("post_rst_grant", 32'(fire_g), 32'd0);
    quiet();
    cycle();

    // Random traffic over words 0..15, junk in ignored address bits
    for (int i = 0; i < 400; i++) begin
      rst_n          = ($urandom_range(0, 63) != 0);
      m0_req_valid_i = $urandom_range(0, 3) != 0;
      m1_req_valid_i = $urandom_range(0, 3) != 0;
      m0_rsp_ready_i = $urandom_range(0, 3) != 0;
      m1_rsp_ready_i = $urandom_range(0, 3) != 0;
      m0_we_i        = $urandom_range(0, 1) == 1;
      m1_we_i        = $urandom_range(0, 1) == 1;
      m0_sel_i       = 4'($urandom);
      m1_sel_i       = 4'($urandom);
      m0_data_i      = $urandom;
      m1_data_i      = $urandom;
      m0_addr_i      = ($urandom & 32'hFFFF8000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
      m1_addr_i      = ($urandom & 32'hFFFF8000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
      cycle();
    end

    rst_n = 1'b1;
    quiet();
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 The block SHALL take one parameter, AW, default 13, giving the RAM word-address width.
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all logic SHALL be rising-edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit, a reset that is synchronous and active-low.
REQ-004 For each requester N in {0,1}, the block SHALL have mN_req_valid_i, input, 1 bit, request valid.
REQ-005 For each requester N in {0,1}, the block SHALL have mN_req_ready_o, output, 1 bit, request accepted this cycle.
REQ-006 For each requester N in {0,1}, the block SHALL have mN_addr_i, input, 32 bits, byte address; bits [AW+1:2] select the word.
REQ-007 For each requester N in {0,1}, the block SHALL have mN_data_i, input, 32 bits, write data.
REQ-008 For each requester N in {0,1}, the block SHALL have mN_sel_i, input, 4 bits, byte enables.
REQ-009 For each requester N in {0,1}, the block SHALL have mN_we_i, input, 1 bit, 1 for write and 0 for read.
REQ-010 For each requester N in {0,1}, the block SHALL have mN_data_o, output, 32 bits, response read data.
REQ-011 For each requester N in {0,1}, the block SHALL have mN_rsp_valid_o, output, 1 bit, response valid.
REQ-012 For each requester N in {0,1}, the block SHALL have mN_rsp_ready_i, input, 1 bit, requester accepts the response.
REQ-013 The block SHALL have s_addr_o, output, AW bits, RAM word address.
REQ-014 The block SHALL have s_data_o, output, 32 bits, RAM write data.
REQ-015 The block SHALL have s_sel_o, output, 4 bits, RAM byte enables.
REQ-016 The block SHALL have s_we_o, output, 1 bit, RAM write enable; it is high only in an accept cycle of a write.
REQ-017 The block SHALL have s_data_i, input, 32 bits, RAM read data, valid on the cycle after the address is presented.

Function
REQ-018 The FSM SHALL have the states IDLE, RSP0 and RSP1; RSPn means one response is owed to requester n.
REQ-019 A request is accepted ("fire") when the FSM is in IDLE, or when it is in RSPn and mn_rsp_ready_i=1 in that same cycle.
REQ-020 In any other cycle, both mN_req_ready_o outputs SHALL be 0.
REQ-021 On a fire cycle, exactly one requester's mN_req_ready_o SHALL be 1, and only if its mN_req_valid_i=1.
REQ-022 mN_req_ready_o SHALL depend combinationally on the valids; there is no bubble between requests.
REQ-023 If only one requester is valid, it SHALL be granted.
REQ-024 If both are valid, the requester not granted last SHALL win (round-robin).
REQ-025 A last_grant flop SHALL update on every fire; its reset value is 1, so m0 wins the first conflict.
REQ-026 In a fire cycle, s_addr_o, s_data_o, s_sel_o and s_we_o SHALL be driven combinationally from the granted requester.
REQ-027 In non-fire cycles, s_we_o SHALL be 0, and s_addr_o, s_data_o and s_sel_o are don't-care.
REQ-028 A fire SHALL move the FSM to RSPg, where g is the granted requester.
REQ-029 In RSPn, a response handshake with no new fire SHALL return the FSM to IDLE; with a new fire it SHALL go to RSPg'.
REQ-030 mn_rsp_valid_o SHALL be 1 exactly while the FSM is in RSPn; the other requester's rsp_valid SHALL be 0.
REQ-031 Response latency SHALL be 1 cycle: rsp_valid asserts on the cycle after the fire.
REQ-032 On the first RSP cycle, mN_data_o SHALL equal s_data_i for a read and 32'h0 for a write.
REQ-033 The response data SHALL be captured in a 32-bit register on that first cycle and held stable until the handshake, however long rsp_ready stays low.
REQ-034 Both mN_data_o outputs SHALL show the response data; only rsp_valid qualifies it.
REQ-035 A write SHALL complete at its fire cycle; its response only acknowledges it.
REQ-036 A requester SHALL be allowed to hold valid through back-pressure; its inputs are sampled only at fire.
REQ-037 Sustained throughput SHALL be one request per cycle when rsp_ready is held high.
REQ-038 Address bits above AW+1 and bits [1:0] SHALL be ignored.

Reset
REQ-039 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE, last_grant to 1 and the response register to 32'h0.
REQ-040 During reset, all req_ready, rsp_valid and s_we_o outputs SHALL be 0.
REQ-041 A reset during RSPn SHALL drop the owed response; no rsp_valid SHALL follow it.
REQ-042 A write presented in the reset cycle SHALL NOT reach the RAM.

Verification
REQ-043 Single read: m0 reads address 0x10 while the RAM word holds 0xDEADBEEF -> m0_req_ready=1 at cycle t, and at t+1 m0_rsp_valid=1 with m0_data_o=0xDEADBEEF.
REQ-044 Conflict: both requesters are valid continuously with rsp_ready=1 -> grants go m0, m1, m0, m1, with one fire per cycle.
REQ-045 Back-pressure: m1 reads 0x55AA00FF and holds rsp_ready=0 for 5 cycles -> m1_rsp_valid stays 1 with stable data, no other fire occurs, and m0_req_ready stays 0.
REQ-046 Byte write: m0 writes sel=4'b0010 with data 0x0000AB00 over 0x11223344, then reads back -> the read returns 0x1122AB44, and the write response data is 0.
REQ-047 Reset in RSP0: rst_n=0 for 1 cycle while in RSP0 -> m0_rsp_valid is 0 from the next cycle, and the next conflict is granted to m0.
REQ-048 Idle: no requests for 10 cycles -> s_we_o, both req_ready and both rsp_valid stay 0.
